// File: rtl/sample_bank_ctrl_pkg.sv
// Shared encoder definitions for the ping-pong sample bank controller.
// Holds the read-FSM state encoding and the sample RAM geometry used by
// the controller, its reader sub-module and the bus interface.
package sample_bank_ctrl_pkg;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_RUN   = 2'd1,
        R_DRAIN = 2'd2
    } rd_state_t;

    localparam int RAM_DEPTH = 8192;
    localparam int SAMPLE_W  = 16;

endpackage

// File: rtl/sample_bank_ctrl_if.sv
// Bus bundle for sample_bank_ctrl: producer handshake, consumer stream and
// the two RAM ports. The controller uses the slave modport; the environment
// (producer, consumer, RAM) uses the master modport.
//   producer : iSample, iValid, oReady, iFlush
//   consumer : oBlockAvail, oBlockLen, iStartRead, oSample, oSampleValid, oLastSample
//   RAM      : oRamData1, oRamWAddr1, oRamWE1, oRamRAddr2, iRamQ2, oRamWE2
interface sample_bank_ctrl_if
    import sample_bank_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 13
) ();

    logic [SAMPLE_W-1:0] iSample;
    logic                iValid;
    logic                oReady;
    logic                iFlush;
    logic                oBlockAvail;
    logic [LEN_W-1:0]    oBlockLen;
    logic                iStartRead;
    logic [SAMPLE_W-1:0] oSample;
    logic                oSampleValid;
    logic                oLastSample;
    logic [SAMPLE_W-1:0] oRamData1;
    logic [ADDR_W-1:0]   oRamWAddr1;
    logic                oRamWE1;
    logic [ADDR_W-1:0]   oRamRAddr2;
    logic [SAMPLE_W-1:0] iRamQ2;
    logic                oRamWE2;

    modport slave (
        input  iSample, iValid, iFlush, iStartRead, iRamQ2,
        output oReady, oBlockAvail, oBlockLen, oSample, oSampleValid, oLastSample,
               oRamData1, oRamWAddr1, oRamWE1, oRamRAddr2, oRamWE2
    );

    modport master (
        output iSample, iValid, iFlush, iStartRead, iRamQ2,
        input  oReady, oBlockAvail, oBlockLen, oSample, oSampleValid, oLastSample,
               oRamData1, oRamWAddr1, oRamWE1, oRamRAddr2, oRamWE2
    );

endinterface

// File: rtl/sample_bank_reader.sv
// Read side of the ping-pong controller: owns the read bank pointer, issues
// one RAM port-2 address per cycle for the waiting block and delays the
// valid/last qualifiers by one cycle to line up with the registered RAM data.
// Ports:
//   iClock, iReset_n          clock, synchronous active-low reset
//   iBlockFull, iBlockLen     full flag and length of the bank at oBank
//   iStartRead                consumer start request
//   oBank                     bank currently owned by the reader
//   oDrain                    high in the cycle whose edge releases oBank
//   oBlockAvail, oBlockLen    waiting-block indication to the consumer
//   oRamRAddr2                registered RAM read address
//   oSampleValid, oLastSample registered stream qualifiers
//
// state   | meaning
// R_IDLE  | waiting for a full bank and a start request
// R_RUN   | issuing one read address per cycle
// R_DRAIN | last read data returning; bank is released at the next edge
module sample_bank_reader
    import sample_bank_ctrl_pkg::*;
#(
    parameter int BLOCK_SIZE = 4096,
    parameter int ADDR_W     = 16,
    parameter int LEN_W      = 13
) (
    input  logic              iClock,
    input  logic              iReset_n,
    input  logic              iBlockFull,
    input  logic [LEN_W-1:0]  iBlockLen,
    input  logic              iStartRead,
    output logic              oBank,
    output logic              oDrain,
    output logic              oBlockAvail,
    output logic [LEN_W-1:0]  oBlockLen,
    output logic [ADDR_W-1:0] oRamRAddr2,
    output logic              oSampleValid,
    output logic              oLastSample
);

    rd_state_t         state;
    logic [LEN_W-1:0]  rindex;      // next index to issue
    logic              issue;       // oRamRAddr2 holds a live address
    logic              issue_last;  // ...and it is the block's final one
    logic [ADDR_W-1:0] base;

    assign base        = oBank ? ADDR_W'(BLOCK_SIZE) : '0;
    assign oBlockAvail = (state == R_IDLE) && iBlockFull;
    assign oBlockLen   = oBlockAvail ? iBlockLen : '0;
    assign oDrain      = (state == R_DRAIN);

    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            state        <= R_IDLE;
            oBank        <= 1'b0;
            rindex       <= '0;
            issue        <= 1'b0;
            issue_last   <= 1'b0;
            oRamRAddr2   <= '0;
            oSampleValid <= 1'b0;
            oLastSample  <= 1'b0;
        end else begin
            // RAM data lags the address by one edge
            oSampleValid <= issue;
            oLastSample  <= issue & issue_last;
            case (state)
                R_IDLE: begin
                    if (iStartRead && oBlockAvail) begin
                        state      <= R_RUN;
                        oRamRAddr2 <= base;
                        issue      <= 1'b1;
                        issue_last <= (iBlockLen == LEN_W'(1));
                        rindex     <= LEN_W'(1);
                    end
                end
                R_RUN: begin
                    if (issue_last) begin
                        issue      <= 1'b0;
                        issue_last <= 1'b0;
                        state      <= R_DRAIN;
                    end else begin
                        oRamRAddr2 <= base + ADDR_W'(rindex);
                        issue_last <= (rindex == iBlockLen - LEN_W'(1));
                        rindex     <= rindex + LEN_W'(1);
                    end
                end
                R_DRAIN: begin
                    oBank <= ~oBank;
                    state <= R_IDLE;
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sample_bank_ctrl.sv
// Ping-pong bank controller for the encoder's dual-port sample RAM. The
// producer fills one bank through RAM port 1 while the reader streams the
// other bank out through RAM port 2. Short blocks are closed with iFlush.
// Ports:
//   iClock    sole clock, rising edge
//   iReset_n  synchronous active-low reset
//   bus       sample_bank_ctrl_if.slave (producer, consumer and RAM signals)
module sample_bank_ctrl
    import sample_bank_ctrl_pkg::*;
#(
    parameter int BLOCK_SIZE = 4096,
    parameter int ADDR_W     = 16,
    parameter int LEN_W      = 13
) (
    input  logic              iClock,
    input  logic              iReset_n,
    sample_bank_ctrl_if.slave bus
);

    localparam int IDX_W = (BLOCK_SIZE > 2) ? $clog2(BLOCK_SIZE) : 1;

    logic              wbank;
    logic [IDX_W-1:0]  windex;
    logic [1:0]        full;
    logic [LEN_W-1:0]  blk_len [2];
    logic              accept;
    logic              close_full;
    logic              close_short;
    logic              rbank;
    logic              drain;
    logic              rd_avail;
    logic [LEN_W-1:0]  rd_len;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              rd_last;

    assign bus.oReady = ~full[wbank];
    assign accept     = bus.iValid & bus.oReady;
    assign close_full = accept && (windex == IDX_W'(BLOCK_SIZE - 1));
    // A flush only closes a bank that holds (or is receiving) at least one sample;
    // a flush landing on the block-completing sample is just a full block.
    assign close_short = bus.iFlush && !close_full && ((windex != '0) || accept);

    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            wbank          <= 1'b0;
            windex         <= '0;
            full           <= '0;
            blk_len[0]     <= '0;
            blk_len[1]     <= '0;
            bus.oRamWE1    <= 1'b0;
            bus.oRamWAddr1 <= '0;
            bus.oRamData1  <= '0;
        end else begin
            bus.oRamWE1 <= accept;
            if (accept) begin
                bus.oRamWAddr1 <= (wbank ? ADDR_W'(BLOCK_SIZE) : '0) + ADDR_W'(windex);
                bus.oRamData1  <= bus.iSample;
            end
            if (close_full || close_short) begin
                full[wbank]    <= 1'b1;
                blk_len[wbank] <= close_full ? LEN_W'(BLOCK_SIZE)
                                             : LEN_W'(windex) + LEN_W'(accept);
                wbank          <= ~wbank;
                windex         <= '0;
            end else if (accept) begin
                windex <= windex + IDX_W'(1);
            end
            // Reader always releases the bank the writer is not closing.
            if (drain) begin
                full[rbank] <= 1'b0;
            end
        end
    end

    sample_bank_reader #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W)
    ) u_reader (
        .iClock       (iClock),
        .iReset_n     (iReset_n),
        .iBlockFull   (full[rbank]),
        .iBlockLen    (blk_len[rbank]),
        .iStartRead   (bus.iStartRead),
        .oBank        (rbank),
        .oDrain       (drain),
        .oBlockAvail  (rd_avail),
        .oBlockLen    (rd_len),
        .oRamRAddr2   (rd_addr),
        .oSampleValid (rd_valid),
        .oLastSample  (rd_last)
    );

    assign bus.oBlockAvail  = rd_avail;
    assign bus.oBlockLen    = rd_len;
    assign bus.oRamRAddr2   = rd_addr;
    assign bus.oSampleValid = rd_valid;
    assign bus.oLastSample  = rd_last;
    assign bus.oSample      = bus.iRamQ2;
    assign bus.oRamWE2      = 1'b0;

endmodule

// File: tb/tb_sample_bank_ctrl.sv
// Directed bench for sample_bank_ctrl with BLOCK_SIZE=8 and a behavioural
// dual-port RAM (registered port-2 read).
module tb_sample_bank_ctrl;
    import sample_bank_ctrl_pkg::*;

    localparam int BS = 8;

    logic iClock = 1'b0;
    logic iReset_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 iClock = ~iClock;

    sample_bank_ctrl_if #(.ADDR_W(16), .LEN_W(13)) bus ();

    sample_bank_ctrl #(.BLOCK_SIZE(BS), .ADDR_W(16), .LEN_W(13)) dut (
        .iClock   (iClock),
        .iReset_n (iReset_n),
        .bus      (bus)
    );

    logic [SAMPLE_W-1:0] mem [RAM_DEPTH];

    always @(posedge iClock) begin
        if (bus.oRamWE1) mem[bus.oRamWAddr1[12:0]] <= bus.oRamData1;
        bus.iRamQ2 <= mem[bus.oRamRAddr2[12:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_ready",  bus.oReady,       1);
        chk("rst_avail",  bus.oBlockAvail,  0);
        chk("rst_len",    bus.oBlockLen,    0);
        chk("rst_valid",  bus.oSampleValid, 0);
        chk("rst_last",   bus.oLastSample,  0);
        chk("rst_we1",    bus.oRamWE1,      0);
        chk("rst_waddr1", bus.oRamWAddr1,   0);
        chk("rst_data1",  bus.oRamData1,    0);
        chk("rst_raddr2", bus.oRamRAddr2,   0);
        chk("rst_we2",    bus.oRamWE2,      0);
    endtask

    task automatic put(input logic [15:0] v, input logic fl);
        int t = 0;
        @(negedge iClock);
        bus.iSample = v;
        bus.iValid  = 1'b1;
        bus.iFlush  = fl;
        while (!bus.oReady && t < 100) begin
            @(negedge iClock);
            t++;
        end
        if (t >= 100) chk("ready_wait", bus.oReady, 1);
        @(posedge iClock);
        #1;
        bus.iValid = 1'b0;
        bus.iFlush = 1'b0;
    endtask

    task automatic flush_only();
        @(negedge iClock);
        bus.iFlush = 1'b1;
        @(posedge iClock);
        #1 bus.iFlush = 1'b0;
    endtask

    task automatic read_block(input int len, input logic [15:0] first);
        int t = 0;
        @(negedge iClock);
        while (!bus.oBlockAvail && t < 60) begin
            @(negedge iClock);
            t++;
        end
        chk("blk_avail", bus.oBlockAvail, 1);
        if (!bus.oBlockAvail) return;
        chk("blk_len", bus.oBlockLen, len);
        bus.iStartRead = 1'b1;
        @(posedge iClock);
        #1 bus.iStartRead = 1'b0;
        @(negedge iClock);
        chk("rd_latency", bus.oSampleValid, 0);
        for (int i = 0; i < len; i++) begin
            @(negedge iClock);
            chk("rd_valid", bus.oSampleValid, 1);
            chk("rd_data",  bus.oSample, first + 16'(i));
            chk("rd_last",  bus.oLastSample, (i == len - 1));
        end
        @(negedge iClock);
        chk("rd_end", bus.oSampleValid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iSample    = '0;
        bus.iValid     = 1'b0;
        bus.iFlush     = 1'b0;
        bus.iStartRead = 1'b0;
        iReset_n       = 1'b0;
        repeat (2) @(posedge iClock);
        #1;
        check_reset();
        iReset_n = 1'b1;

        // full block of 8 into bank 0
        put(16'h100, 1'b0);
        chk("wr_we",   bus.oRamWE1,    1);
        chk("wr_addr", bus.oRamWAddr1, 0);
        chk("wr_data", bus.oRamData1,  16'h100);
        for (int i = 1; i < 8; i++) put(16'h100 + 16'(i), 1'b0);
        chk("wr_addr_end", bus.oRamWAddr1, 7);
        chk("wr_ready_b1", bus.oReady, 1);
        read_block(8, 16'h100);

        // 16 samples without reading: both banks fill, writer stalls
        put(16'h200, 1'b0);
        chk("wr_addr_b1", bus.oRamWAddr1, 8);
        for (int i = 1; i < 16; i++) put(16'h200 + 16'(i), 1'b0);
        chk("both_full_ready", bus.oReady, 0);
        chk("both_full_avail", bus.oBlockAvail, 1);
        fork
            begin
                put(16'h210, 1'b0);
                chk("held_addr", bus.oRamWAddr1, 8);
            end
            begin
                read_block(8, 16'h200);
                read_block(8, 16'h208);
            end
        join
        flush_only();
        read_block(1, 16'h210);

        // short block by separate flush, then flush on an empty bank
        for (int i = 0; i < 3; i++) put(16'h300 + 16'(i), 1'b0);
        flush_only();
        read_block(3, 16'h300);
        flush_only();
        repeat (3) @(negedge iClock);
        chk("flush0_avail", bus.oBlockAvail, 0);
        chk("flush0_ready", bus.oReady, 1);

        // flush coinciding with the 5th sample
        put(16'h400, 1'b0);
        chk("wr_addr_t4", bus.oRamWAddr1, 8);
        for (int i = 1; i < 4; i++) put(16'h400 + 16'(i), 1'b0);
        put(16'h404, 1'b1);
        read_block(5, 16'h400);

        // flush coinciding with the block-completing sample
        for (int i = 0; i < 7; i++) put(16'h500 + 16'(i), 1'b0);
        put(16'h507, 1'b1);
        read_block(8, 16'h500);
        repeat (3) @(negedge iClock);
        chk("no_extra_blk", bus.oBlockAvail, 0);

        // concurrent streaming over 4 blocks
        fork
            begin
                for (int i = 0; i < 32; i++) put(16'h600 + 16'(i), 1'b0);
            end
            begin
                for (int k = 0; k < 4; k++) read_block(8, 16'h600 + 16'(8 * k));
            end
        join

        // reset in the middle of a readout
        for (int i = 0; i < 8; i++) put(16'h700 + 16'(i), 1'b0);
        @(negedge iClock);
        bus.iStartRead = 1'b1;
        @(posedge iClock);
        #1 bus.iStartRead = 1'b0;
        repeat (3) @(posedge iClock);
        @(negedge iClock);
        iReset_n = 1'b0;
        @(posedge iClock);
        #1;
        check_reset();
        iReset_n = 1'b1;
        repeat (3) @(negedge iClock);
        chk("post_rst_avail", bus.oBlockAvail, 0);
        put(16'h800, 1'b0);
        chk("post_rst_addr", bus.oRamWAddr1, 0);
        put(16'h801, 1'b0);
        flush_only();
        read_block(2, 16'h800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_bank_ctrl.md
# sample_bank_ctrl

Ping-pong bank controller for the encoder's 8192×16 dual-port sample RAM. Incoming PCM samples are written into one bank (RAM port 1) while the previously filled bank is streamed out through RAM port 2 to the downstream stage (LPC/residual). The controller tracks bank ownership, block lengths, short final blocks, and the RAM's one-cycle read latency, so producer and consumer never see RAM addresses.

## Interface
- BLOCK_SIZE, 4096: samples per full block; power of two, 2..4096.
- ADDR_W, 16: RAM address width.
- LEN_W, 13: width of block-length output; must hold BLOCK_SIZE.

- iClock  in  1  rising-edge clock, sole clock domain.
- iReset_n  in  1  reset, synchronous, active-low.
- iSample  in  16  producer sample.
- iValid  in  1  producer sample valid; accepted when iValid && oReady.
- oReady  out  1  current write bank is free.
- iFlush  in  1  close current partial bank as a short block.
- oBlockAvail  out  1  a filled bank is waiting and reader is idle.
- oBlockLen  out  LEN_W  length of waiting block; valid while oBlockAvail.
- iStartRead  in  1  consumer request to stream the waiting block.
- oSample  out  16  streamed sample; equals iRamQ2.
- oSampleValid  out  1  oSample valid this cycle.
- oLastSample  out  1  qualifies final sample of the block.
- oRamData1  out  16  RAM port-1 write data.
- oRamWAddr1  out  ADDR_W  RAM port-1 write address.
- oRamWE1  out  1  RAM port-1 write enable.
- oRamRAddr2  out  ADDR_W  RAM port-2 read address.
- iRamQ2  in  16  RAM port-2 registered read data.
- oRamWE2  out  1  tied 0; port-2 write is unused.

## Operation
- Bank b base = b·BLOCK_SIZE. Per-bank state: full[b], len[b].
- Write side: wbank, windex. Accepted sample → registered write to base(wbank)+windex; windex++. On windex == BLOCK_SIZE-1: full[wbank]=1, len=BLOCK_SIZE, wbank toggles, windex=0.
- oReady = !full[wbank]. No write while not ready; iValid held is not an error.
- iFlush with windex>0: full[wbank]=1, len=windex (+1 if a sample is accepted the same cycle), toggle wbank, windex=0. iFlush with windex==0 and no accepted sample: ignored. Flush coinciding with the sample that completes a block: normal full block, no extra action.
- Read FSM: R_IDLE → R_RUN on iStartRead && oBlockAvail (rindex=0). R_RUN issues base(rbank)+rindex each cycle; after issuing index len[rbank]-1 → R_DRAIN. R_DRAIN (one cycle, last data returns): clear full[rbank], toggle rbank → R_IDLE.
- oBlockAvail = (state==R_IDLE) && full[rbank]; iStartRead otherwise ignored.
- Readout is non-stallable: one sample per cycle, consumer must accept.
- full[] set (write side) and clear (read side) always target different banks; both may occur in one cycle.

## Timing
- Reset: oReady=1 after reset, oBlockAvail=0, oBlockLen=0, oSampleValid=0, oLastSample=0, oRamWE1=0, oRamWAddr1=0, oRamData1=0, oRamRAddr2=0, oRamWE2=0; full=0, banks 0, indices 0, FSM R_IDLE. RAM contents disregarded. Reset mid-block discards both banks.
- Write: sample accepted at edge N → oRamWE1/address/data valid N..N+1, RAM written at N+1. full visible after N.
- Read: start accepted at edge E → first address registered at E; RAM captures at E+1; oSampleValid high the cycle after E+1; len consecutive valid cycles; oLastSample with the final one.
- Earliest read of a just-filled bank occurs ≥1 edge after its last write: no read-before-write hazard.
- Throughput: one sample in and one out per cycle sustained; reader idle 1 cycle (R_DRAIN→R_IDLE) plus start handshake between blocks.

## Structure
- Shared encoder package: read-FSM state encoding (R_IDLE, R_RUN, R_DRAIN), RAM depth 8192, sample width 16.
- Natural sub-module: sample_bank_reader (read FSM + valid/last pipeline); write side stays in top.

## Test plan
- BLOCK_SIZE=8: write 0..7, start read → oSample 0..7 on 8 consecutive cycles, oLastSample on 7, oBlockLen=8.
- Write 16 samples without reading → oReady drops after 16th; 17th held off until first bank drained.
- Concurrent: stream continuously while reading previous bank → no gaps on input, data order preserved over 4 blocks.
- Write 3 samples, iFlush → oBlockLen=3, readout 3 samples, last on 3rd; iFlush with windex=0 → no block.
- iFlush in same cycle as 5th sample → oBlockLen=5.
- Reset asserted during R_RUN → next cycle all outputs at reset values, oBlockAvail=0, oReady=1.
